serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b (mod 2^WIDTH) one bit pair per cycle, LSB first,
// and reports the final borrow-out.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             ai, bi, d_bit, br_next;
  logic             last_bit;

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

  // Full-subtractor cell on the current LSB pair and the stored borrow
  always_comb begin
    ai       = a_q[0];
    bi       = b_q[0];
    d_bit    = ai ^ bi ^ br_q;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    last_bit = (cnt_q == LAST_CNT);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they register alongside it
  always_comb begin
    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  // Datapath next values: load on accept, shift one bit per busy cycle, publish on the last bit
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          res_d = '0;
          br_d  = 1'b0;
          cnt_d = '0;
        end
      end
      S_BUSY: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d = {d_bit, res_q[WIDTH-1:1]};
          bout_d = br_next;
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random sweep.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[7];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular subtraction and unsigned compare
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'(int'(x) - int'(y) + 256);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y);
  endfunction

  // One operation: accept on the next edge, then wait (bounded) for done
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit scramble,
                        output logic [W-1:0] d, output logic bo);
    int lat;
    bit busy_err;
    a = ai;
    b = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_err = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_err = 1'b1;
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    check("busy_during_op", 32'(busy_err), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    d  = diff;
    bo = bout;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] d, x, y, held;
    logic         bo;
    int           cycles;
    bit           seen;

    vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, bout: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bout: 1'b1};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bout: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, diff: 8'h00, bout: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h7F, diff: 8'h01, bout: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h80, diff: 8'hFF, bout: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);

    // First edge with rst low accepts the first vector
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b1, d, bo);
      check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
      check($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bout));
    end

    // Result holds while idle with changing inputs
    a = 8'hAA;
    b = 8'h11;
    repeat (3) tick();
    check("idle_hold_diff", 32'(diff), 32'(vecs[6].diff));
    check("idle_hold_bout", 32'(bout), 32'(vecs[6].bout));
    check("idle_busy", 32'(busy), 32'd0);

    // start held high: first result unaffected, next accept after DONE, pulses WIDTH+2 apart
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    tick();
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      cycles++;
    end
    check("hold_first_diff", 32'(diff), 32'(ref_diff(8'h5A, 8'h3C)));
    check("hold_first_bout", 32'(bout), 32'(ref_bout(8'h5A, 8'h3C)));
    a = 8'h10;
    b = 8'h20;
    tick();
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    check("hold_spacing", 32'(cycles), 32'(W + 2));
    check("hold_second_diff", 32'(diff), 32'(ref_diff(8'h10, 8'h20)));
    check("hold_second_bout", 32'(bout), 32'(ref_bout(8'h10, 8'h20)));
    start = 1'b0;
    tick();

    // Reset on the 4th busy edge aborts the operation
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("midrst_no_activity", 32'(seen), 32'd0);
    run_op(8'h77, 8'h11, 1'b0, d, bo);
    check("after_rst_diff", 32'(d), 32'h66);
    check("after_rst_bout", 32'(bo), 32'd0);

    // rst wins over start on the same edge
    held = diff;
    rst = 1'b1;
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_diff", 32'(diff), 32'd0);
    tick();
    check("rst_prio_idle", 32'(busy), 32'd0);
    if (held == 8'h00) $display("note: previous diff was zero");

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y, 1'b1, d, bo);
      check("rand_diff", 32'(d), 32'(ref_diff(x, y)));
      check("rand_bout", 32'(bo), 32'(ref_bout(x, y)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
